// File: rtl/pic_pkg.sv
// pic_pkg: constants shared by the 8259 PIC control logic and its bench.
// Holds ICW/OCW field positions, OCW2 command codes, FSM state codes and
// the priority-rank helper used to compare two IR indices.
package pic_pkg;

  localparam int NUM_IR = 8;

  // ICW field positions
  localparam int ICW1_LTIM_BIT = 3;
  localparam int ICW2_BASE_LSB = 3;
  localparam int ICW4_AEOI_BIT = 1;

  // OCW2 command encodings (cfg_data[7:5])
  localparam logic [2:0] OCW2_CLR_ROT_AEOI = 3'b000;
  localparam logic [2:0] OCW2_NS_EOI       = 3'b001;
  localparam logic [2:0] OCW2_NOP          = 3'b010;
  localparam logic [2:0] OCW2_SP_EOI       = 3'b011;
  localparam logic [2:0] OCW2_SET_ROT_AEOI = 3'b100;
  localparam logic [2:0] OCW2_ROT_NS_EOI   = 3'b101;
  localparam logic [2:0] OCW2_SET_PRI      = 3'b110;
  localparam logic [2:0] OCW2_ROT_SP_EOI   = 3'b111;

  // OCW3 read-register select (cfg_data[1:0])
  localparam logic [1:0] OCW3_RD_IRR = 2'b10;
  localparam logic [1:0] OCW3_RD_ISR = 2'b11;

  // Acknowledge sequencer states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACK1 = 2'd1;
  localparam logic [1:0] ST_ACK2 = 2'd2;

  // Lowest-priority pointer after reset/ICW1, and the spurious vector id
  localparam logic [2:0] LP_RESET    = 3'd7;
  localparam logic [2:0] SPURIOUS_ID = 3'd7;

  // Rank 0 is the highest priority (index lp+1), rank 7 the lowest (lp)
  function automatic logic [2:0] pri_rank(input logic [2:0] idx, input logic [2:0] lp);
    return idx - lp - 3'd1;
  endfunction

endpackage

// File: rtl/pic_priority_resolver.sv
// pic_priority_resolver: rotating find-first. Scans the request vector
// starting at index lp+1 and wrapping, returning the first set bit.
module pic_priority_resolver
  import pic_pkg::*;
(
  input  logic [NUM_IR-1:0] req,
  input  logic [2:0]        lp,
  output logic              valid,
  output logic [2:0]        index
);

  logic [2:0] pos;

  // Walk from lowest to highest rank so the highest-rank hit is kept last
  always_comb begin
    valid = 1'b0;
    index = 3'd0;
    pos   = 3'd0;
    for (int k = NUM_IR - 1; k >= 0; k--) begin
      pos = lp + 3'd1 + 3'(k);
      if (req[pos]) begin
        valid = 1'b1;
        index = pos;
      end
    end
  end

endmodule

// File: rtl/pic_control_logic.sv
// pic_control_logic: IRR/ISR/IMR, priority resolution, INT generation and the
// two-pulse INTA acknowledge sequence of a single-master 8259 PIC.
// Optional feature macro: PIC_ROTATION_EN (programmable lowest-priority
// pointer and rotate-in-AEOI). Without it the pointer is fixed at 7.
module pic_control_logic
  import pic_pkg::*;
#(
  parameter int NUM_IR_P = NUM_IR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_IR-1:0] ir,
  input  logic              inta_n,
  input  logic              a0,
  input  logic [3:0]        icw_stb,
  input  logic [2:0]        ocw_stb,
  input  logic [7:0]        cfg_data,
  input  logic              init_done,
  output logic              int_o,
  output logic [7:0]        vec_o,
  output logic              vec_oe,
  output logic [7:0]        rd_reg
);

  logic [NUM_IR-1:0] imr, irr, isr, ir_prev;
  logic [NUM_IR-1:0] imr_n, irr_n, isr_n;
  logic [4:0]        base, base_n;
  logic              ltim, ltim_n, aeoi, aeoi_n, rd_isr, rd_isr_n;
  logic [2:0]        id, id_n;
  logic [1:0]        state, state_n;
  logic              inta_prev, int_n;
  logic [2:0]        lp;
`ifdef PIC_ROTATION_EN
  logic [2:0]        lp_n;
  logic              rot_aeoi, rot_aeoi_n;
`endif

  logic              cand_valid, isr_valid, req_cond;
  logic [2:0]        cand, isr_top;
  logic              inta_fall, inta_rise;
  logic [2:0]        ocw2_cmd, ocw2_lvl;
  logic              unused_icw3;

  assign unused_icw3 = icw_stb[2] ^ (NUM_IR_P != NUM_IR);

  assign inta_fall = inta_prev & ~inta_n;
  assign inta_rise = ~inta_prev & inta_n;
  assign ocw2_cmd  = cfg_data[7:5];
  assign ocw2_lvl  = cfg_data[2:0];

`ifndef PIC_ROTATION_EN
  assign lp = LP_RESET;
`endif

  pic_priority_resolver u_cand_res (
    .req   (irr & ~imr),
    .lp    (lp),
    .valid (cand_valid),
    .index (cand)
  );

  pic_priority_resolver u_isr_res (
    .req   (isr),
    .lp    (lp),
    .valid (isr_valid),
    .index (isr_top)
  );

  assign req_cond = cand_valid &&
                    (!isr_valid || (pri_rank(cand, lp) < pri_rank(isr_top, lp)));

  assign vec_oe = (state == ST_ACK2) && !inta_n;
  assign vec_o  = vec_oe ? {base, id} : 8'h00;
  assign rd_reg = a0 ? imr : (rd_isr ? isr : irr);

  // Next-state: config writes, then OCW2 EOI, then FSM events; ICW1 overrides all
  always_comb begin
    imr_n    = imr;
    irr_n    = ltim ? ir : (irr | (ir & ~ir_prev));
    isr_n    = isr;
    base_n   = base;
    ltim_n   = ltim;
    aeoi_n   = aeoi;
    rd_isr_n = rd_isr;
    id_n     = id;
    state_n  = state;
`ifdef PIC_ROTATION_EN
    lp_n       = lp;
    rot_aeoi_n = rot_aeoi;
`endif

    if (icw_stb[1]) base_n = cfg_data[7:ICW2_BASE_LSB];
    if (icw_stb[3]) aeoi_n = cfg_data[ICW4_AEOI_BIT];
    if (ocw_stb[0]) imr_n = cfg_data;
    if (ocw_stb[2]) begin
      if (cfg_data[1:0] == OCW3_RD_IRR) rd_isr_n = 1'b0;
      else if (cfg_data[1:0] == OCW3_RD_ISR) rd_isr_n = 1'b1;
    end

    if (ocw_stb[1]) begin
      case (ocw2_cmd)
        OCW2_NS_EOI, OCW2_ROT_NS_EOI: begin
          if (isr_valid) begin
            isr_n[isr_top] = 1'b0;
`ifdef PIC_ROTATION_EN
            if (ocw2_cmd == OCW2_ROT_NS_EOI) lp_n = isr_top;
`endif
          end
        end
        OCW2_SP_EOI, OCW2_ROT_SP_EOI: begin
          if (isr_valid) begin
            isr_n[ocw2_lvl] = 1'b0;
`ifdef PIC_ROTATION_EN
            if (ocw2_cmd == OCW2_ROT_SP_EOI) lp_n = ocw2_lvl;
`endif
          end
        end
        OCW2_SET_PRI: begin
`ifdef PIC_ROTATION_EN
          lp_n = ocw2_lvl;
`endif
        end
        OCW2_SET_ROT_AEOI: begin
`ifdef PIC_ROTATION_EN
          rot_aeoi_n = 1'b1;
`endif
        end
        OCW2_CLR_ROT_AEOI: begin
`ifdef PIC_ROTATION_EN
          rot_aeoi_n = 1'b0;
`endif
        end
        OCW2_NOP: begin
        end
        default: begin
        end
      endcase
    end

    if (!init_done) begin
      state_n = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (inta_fall) begin
            state_n = ST_ACK1;
            if (cand_valid) begin
              isr_n[cand] = 1'b1;
              irr_n[cand] = 1'b0;
              id_n        = cand;
            end else begin
              id_n = SPURIOUS_ID;
            end
          end
        end
        ST_ACK1: begin
          if (inta_fall) state_n = ST_ACK2;
        end
        ST_ACK2: begin
          if (inta_rise) begin
            state_n = ST_IDLE;
            if (aeoi) begin
              isr_n[id] = 1'b0;
`ifdef PIC_ROTATION_EN
              if (rot_aeoi) lp_n = id;
`endif
            end
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end

    int_n = init_done && (state == ST_IDLE) && !inta_fall && req_cond;

    if (icw_stb[0]) begin
      ltim_n   = cfg_data[ICW1_LTIM_BIT];
      imr_n    = '0;
      isr_n    = '0;
      irr_n    = '0;
      aeoi_n   = 1'b0;
      rd_isr_n = 1'b0;
      state_n  = ST_IDLE;
      int_n    = 1'b0;
`ifdef PIC_ROTATION_EN
      lp_n       = LP_RESET;
      rot_aeoi_n = 1'b0;
`endif
    end
  end

  // Register all control state; reset returns everything to power-up values
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      imr       <= '0;
      irr       <= '0;
      isr       <= '0;
      ir_prev   <= '0;
      base      <= '0;
      ltim      <= 1'b0;
      aeoi      <= 1'b0;
      rd_isr    <= 1'b0;
      id        <= 3'd0;
      state     <= ST_IDLE;
      inta_prev <= 1'b1;
      int_o     <= 1'b0;
    end else begin
      imr       <= imr_n;
      irr       <= irr_n;
      isr       <= isr_n;
      ir_prev   <= ir;
      base      <= base_n;
      ltim      <= ltim_n;
      aeoi      <= aeoi_n;
      rd_isr    <= rd_isr_n;
      id        <= id_n;
      state     <= state_n;
      inta_prev <= inta_n;
      int_o     <= int_n;
    end
  end

`ifdef PIC_ROTATION_EN
  // Programmable lowest-priority pointer and rotate-in-AEOI flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lp       <= LP_RESET;
      rot_aeoi <= 1'b0;
    end else begin
      lp       <= lp_n;
      rot_aeoi <= rot_aeoi_n;
    end
  end
`endif

endmodule

// File: tb/tb_pic_control_logic.sv
// tb_pic_control_logic: directed self-checking bench for pic_control_logic.
// A register read-back table plus hand-written INTA sequences; the expected
// first vector in the rotation test depends on PIC_ROTATION_EN.
module tb_pic_control_logic;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] ir;
  logic       inta_n;
  logic       a0;
  logic [3:0] icw_stb;
  logic [2:0] ocw_stb;
  logic [7:0] cfg_data;
  logic       init_done;
  logic       int_o;
  logic [7:0] vec_o;
  logic       vec_oe;
  logic [7:0] rd_reg;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [3:0] icw;
    logic [2:0] ocw;
    logic [7:0] data;
    logic       a0;
    logic [7:0] exp_rd;
    logic       exp_int;
  } vec_t;

  vec_t tbl [8];

  pic_control_logic dut (
    .clk       (clk),
    .rst       (rst),
    .ir        (ir),
    .inta_n    (inta_n),
    .a0        (a0),
    .icw_stb   (icw_stb),
    .ocw_stb   (ocw_stb),
    .cfg_data  (cfg_data),
    .init_done (init_done),
    .int_o     (int_o),
    .vec_o     (vec_o),
    .vec_oe    (vec_oe),
    .rd_reg    (rd_reg)
  );

  // 100 MHz free-running clock
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [7:0] actual,
                              input logic [7:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %02h expected %02h", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input logic [3:0] icw, input logic [2:0] ocw,
                                input logic [7:0] data);
    icw_stb  = icw;
    ocw_stb  = ocw;
    cfg_data = data;
    tick();
    icw_stb  = 4'b0000;
    ocw_stb  = 3'b000;
  endtask

  task automatic pulse_ir(input logic [7:0] mask);
    ir = mask;
    tick();
    ir = 8'h00;
  endtask

  // Full two-pulse acknowledge; ISR read-back must already be selected
  task automatic inta_cycle(input string name, input logic [7:0] exp_vec,
                            input logic [7:0] exp_isr);
    a0 = 1'b0;
    inta_n = 1'b0;
    tick();
    check_output({name, "_ack1_int"}, int_o, 1'b0);
    check_output({name, "_ack1_isr"}, rd_reg, exp_isr);
    check_output({name, "_ack1_oe"}, vec_oe, 1'b0);
    inta_n = 1'b1;
    tick();
    inta_n = 1'b0;
    tick();
    check_output({name, "_ack2_oe"}, vec_oe, 1'b1);
    check_output({name, "_vec"}, vec_o, exp_vec);
    check_output({name, "_ack2_int"}, int_o, 1'b0);
    inta_n = 1'b1;
    #1;
    check_output({name, "_oe_drop"}, vec_oe, 1'b0);
    tick();
  endtask

  initial begin
    logic [7:0] first_vec, first_isr, second_vec, second_isr;

    // Read-back table, starting with ISR=08, IRR=00, IMR=00
    tbl[0] = '{4'b0000, 3'b100, 8'h0A, 1'b0, 8'h00, 1'b0};
    tbl[1] = '{4'b0000, 3'b001, 8'hA5, 1'b1, 8'hA5, 1'b0};
    tbl[2] = '{4'b0000, 3'b100, 8'h0B, 1'b0, 8'h08, 1'b0};
    tbl[3] = '{4'b0000, 3'b100, 8'h01, 1'b0, 8'h08, 1'b0};
    tbl[4] = '{4'b0100, 3'b000, 8'hFF, 1'b1, 8'hA5, 1'b0};
    tbl[5] = '{4'b0000, 3'b001, 8'h00, 1'b1, 8'h00, 1'b0};
    tbl[6] = '{4'b0000, 3'b100, 8'h0A, 1'b0, 8'h00, 1'b0};
    tbl[7] = '{4'b0000, 3'b100, 8'h0B, 1'b0, 8'h08, 1'b0};

    rst = 1'b1; ir = 8'h00; inta_n = 1'b1; a0 = 1'b0;
    icw_stb = 4'b0000; ocw_stb = 3'b000; cfg_data = 8'h00; init_done = 1'b0;
    #22;
    check_output("rst_int", int_o, 1'b0);
    check_output("rst_oe", vec_oe, 1'b0);
    check_output("rst_vec", vec_o, 8'h00);
    check_output("rst_irr", rd_reg, 8'h00);
    a0 = 1'b1; #1;
    check_output("rst_imr", rd_reg, 8'h00);
    a0 = 1'b0;
    rst = 1'b0;
    tick();

    // Initialization: edge mode, base 08h, normal EOI, ISR read-back
    apply_stimulus(4'b0001, 3'b000, 8'h13);
    apply_stimulus(4'b0010, 3'b000, 8'h08);
    apply_stimulus(4'b1000, 3'b000, 8'h01);
    apply_stimulus(4'b0000, 3'b001, 8'h00);
    apply_stimulus(4'b0000, 3'b100, 8'h0B);
    init_done = 1'b1;

    // Basic request/acknowledge on IR3
    pulse_ir(8'h08);
    check_output("ir3_latency", int_o, 1'b0);
    tick();
    check_output("ir3_int", int_o, 1'b1);
    inta_cycle("ir3", 8'h0B, 8'h08);
    check_output("ir3_isr_after", rd_reg, 8'h08);
    check_output("ir3_int_after", int_o, 1'b0);

    // Register read-back table
    for (int i = 0; i < 8; i++) begin
      if ((tbl[i].icw != 4'b0000) || (tbl[i].ocw != 3'b000))
        apply_stimulus(tbl[i].icw, tbl[i].ocw, tbl[i].data);
      a0 = tbl[i].a0;
      #1;
      check_output($sformatf("tbl%0d_rd", i), rd_reg, tbl[i].exp_rd);
      check_output($sformatf("tbl%0d_int", i), int_o, tbl[i].exp_int);
    end
    a0 = 1'b0;

    // Fully nested: IR5 blocked by ISR3, IR2 outranks it
    ir = 8'h20;
    tick(); tick();
    check_output("nest_ir5_blocked", int_o, 1'b0);
    ir = 8'h24;
    tick(); tick();
    check_output("nest_ir2_int", int_o, 1'b1);
    apply_stimulus(4'b0000, 3'b010, 8'h20);
    check_output("nest_eoi_isr", rd_reg, 8'h00);
    inta_cycle("nest_ir2", 8'h0A, 8'h04);
    tick();
    check_output("nest_ir5_still_blocked", int_o, 1'b0);
    apply_stimulus(4'b0000, 3'b010, 8'h20);
    check_output("nest_eoi2_int", int_o, 1'b0);
    tick();
    check_output("nest_ir5_int", int_o, 1'b1);
    inta_cycle("nest_ir5", 8'h0D, 8'h20);
    ir = 8'h00;
    apply_stimulus(4'b0000, 3'b010, 8'h20);
    check_output("nest_final_isr", rd_reg, 8'h00);

    // Masking: IR2 masked then unmasked
    apply_stimulus(4'b0000, 3'b001, 8'h04);
    pulse_ir(8'h04);
    tick();
    check_output("mask_int0", int_o, 1'b0);
    tick();
    check_output("mask_int1", int_o, 1'b0);
    apply_stimulus(4'b0000, 3'b001, 8'h00);
    check_output("unmask_latency", int_o, 1'b0);
    tick();
    check_output("unmask_int", int_o, 1'b1);
    inta_cycle("unmask", 8'h0A, 8'h04);
    apply_stimulus(4'b0000, 3'b010, 8'h62);
    check_output("specific_eoi_isr", rd_reg, 8'h00);

    // Automatic EOI
    apply_stimulus(4'b1000, 3'b000, 8'h03);
    pulse_ir(8'h08);
    tick();
    check_output("aeoi_int", int_o, 1'b1);
    inta_cycle("aeoi", 8'h0B, 8'h08);
    check_output("aeoi_isr_clear", rd_reg, 8'h00);
    apply_stimulus(4'b0000, 3'b100, 8'h0B);
    check_output("aeoi_ocw3_isr", rd_reg, 8'h00);

    // Priority rotation: IR3 and IR5 pending together
`ifdef PIC_ROTATION_EN
    apply_stimulus(4'b0000, 3'b010, 8'hC4);
    first_vec = 8'h0D; first_isr = 8'h20; second_vec = 8'h0B; second_isr = 8'h08;
`else
    first_vec = 8'h0B; first_isr = 8'h08; second_vec = 8'h0D; second_isr = 8'h20;
`endif
    pulse_ir(8'h28);
    tick();
    check_output("rot_int", int_o, 1'b1);
    inta_cycle("rot_first", first_vec, first_isr);
    tick();
    check_output("rot_second_int", int_o, 1'b1);
    inta_cycle("rot_second", second_vec, second_isr);
    check_output("rot_isr_clear", rd_reg, 8'h00);
    apply_stimulus(4'b0000, 3'b010, 8'hC7);

    // Spurious acknowledge with nothing pending
    inta_cycle("spurious", 8'h0F, 8'h00);
    check_output("spurious_isr", rd_reg, 8'h00);

    // Reset in the middle of ACK2
    pulse_ir(8'h08);
    tick();
    check_output("rst_seq_int", int_o, 1'b1);
    inta_n = 1'b0; tick();
    inta_n = 1'b1; tick();
    inta_n = 1'b0; tick();
    check_output("rst_seq_oe_before", vec_oe, 1'b1);
    rst = 1'b1;
    #1;
    check_output("rst_seq_oe", vec_oe, 1'b0);
    check_output("rst_seq_vec", vec_o, 8'h00);
    check_output("rst_seq_int_low", int_o, 1'b0);
    a0 = 1'b0; #1;
    check_output("rst_seq_irr", rd_reg, 8'h00);
    a0 = 1'b1; #1;
    check_output("rst_seq_imr", rd_reg, 8'h00);
    a0 = 1'b0;
    inta_n = 1'b1;
    init_done = 1'b0;
    #1;
    rst = 1'b0;
    tick();

    // init_done low holds off int_o while strobes still configure
    apply_stimulus(4'b0001, 3'b000, 8'h13);
    apply_stimulus(4'b0010, 3'b000, 8'h08);
    apply_stimulus(4'b1000, 3'b000, 8'h01);
    apply_stimulus(4'b0000, 3'b001, 8'h00);
    pulse_ir(8'h08);
    tick(); tick();
    check_output("noinit_int", int_o, 1'b0);
    check_output("noinit_irr", rd_reg, 8'h08);
    init_done = 1'b1;
    tick();
    check_output("init_int", int_o, 1'b1);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pic_control_logic.md
# pic_control_logic

Interrupt sequencing core of the 8259 PIC: holds IRR/ISR/IMR, resolves priority, drives INT and runs the two-pulse INTA acknowledge sequence. Configured by the one-cycle ICW/OCW strobes and data byte produced by the read/write logic block. Returns the register selected for CPU read-back to that same block. Single master only; cascade, poll and special-mask modes are not supported.

## Interface
- Parameters:
- NUM_IR, 8 — number of interrupt lines; fixed at 8, parameter exists for constant sharing only.
- Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- ir  in  8  interrupt request lines, synchronous to clk.
- inta_n  in  1  CPU acknowledge, active low, synchronous to clk.
- a0  in  1  address bit of the current CPU read.
- icw_stb  in  4  one-hot ICW1..ICW4 write strobe (bit0 = ICW1).
- ocw_stb  in  3  one-hot OCW1..OCW3 write strobe (bit0 = OCW1).
- cfg_data  in  8  data byte qualified by the strobes.
- init_done  in  1  initialization complete.
- int_o  out  1  interrupt request to CPU.
- vec_o  out  8  vector byte.
- vec_oe  out  1  vector drive enable.
- rd_reg  out  8  IMR if a0=1, else IRR or ISR per OCW3.

## Operation
- Reset values: IMR=00, IRR=00, ISR=00, vector base=00, LTIM=0, AEOI=0, rotate-in-AEOI=0, lowest-priority pointer lp=7, read select=IRR, FSM=IDLE, int_o=0, vec_oe=0, vec_o=00.
- ICW1: LTIM=cfg_data[3]; clears IMR, ISR, IRR, AEOI and rotate-in-AEOI; sets lp=7 and read select=IRR; returns FSM to IDLE.
- ICW2: base=cfg_data[7:3]. ICW3: ignored. ICW4: AEOI=cfg_data[1].
- OCW1: IMR=cfg_data.
- OCW2, cmd=cfg_data[7:5], L=cfg_data[2:0]:
- 001: clear highest-priority ISR bit.
- 011: clear ISR[L].
- 101: as 001, then lp=cleared index.
- 111: as 011, then lp=L.
- 110: lp=L.
- 100/000: set/clear rotate-in-AEOI.
- 010: no-op. EOI with ISR=0 is a no-op.
- OCW3: cfg_data[1:0]=10 selects IRR, 11 selects ISR; other values leave the selection unchanged.
- IRR, edge mode (LTIM=0): a bit sets on a 0→1 transition of ir between consecutive clk samples.
- IRR, level mode (LTIM=1): IRR[i] follows ir[i].
- IRR, both modes: the acknowledged bit is cleared at ACK1; in level mode it re-follows ir from the next cycle.
- Priority: highest priority is index lp+1 mod 8, descending cyclically. Candidate = highest-priority bit of IRR & ~IMR.
- Request condition: a candidate exists and outranks the highest-priority set ISR bit (fully nested). Equal or lower priority is blocked.
- FSM IDLE→ACK1 on an inta_n falling edge.
- Entering ACK1, candidate present: ISR[c]=1, IRR[c]=0, captured id=c.
- Entering ACK1, no candidate (spurious): id=7, ISR unchanged.
- FSM ACK1→ACK2 on the second falling edge.
- In ACK2: vec_oe=1 while inta_n=0, vec_o={base,id}.
- On the inta_n rising edge in ACK2: FSM→IDLE. If AEOI, clear ISR[id]; if rotate-in-AEOI is also set, lp=id.
- init_done=0: int_o forced 0 and FSM held in IDLE; strobes are still accepted.

## Timing
- All state updates on the clk edge after the strobe or sampled event; strobes are single-cycle.
- Edge detection: an inta_n edge is seen on the cycle it is first sampled at its new level.
- int_o is registered: it rises 1 cycle after the request condition becomes true.
- int_o falls on the cycle the FSM enters ACK1 and stays low through ACK2.
- int_o re-evaluates from IDLE, with 1-cycle latency.
- vec_oe is combinational from the FSM state and inta_n.
- Simultaneous OCW2 EOI and ACK1 in the same cycle: the EOI is applied first, then ACK1 sets its ISR bit.
- Simultaneous ICW1 with an FSM event: ICW1 wins.
- rst mid-sequence: immediate return to reset values; vec_oe drops asynchronously.

## Configuration
- PIC_ROTATION_EN defined: lp is programmable exactly as described above.
- PIC_ROTATION_EN undefined: lp is fixed at 7 (IR0 highest).
- Without the macro, OCW2 101/111 act as 001/011, 110 and 100/000 are no-ops, and the rotate-in-AEOI flag does not exist.

## Structure
- Shared package pic_pkg: NUM_IR, ICW/OCW field bit-index constants, OCW2 command encodings, FSM state enum (IDLE, ACK1, ACK2).
- Sub-module pic_priority_resolver: combinational rotate + find-first. Inputs: request vector and lp. Outputs: valid flag and 3-bit index. Instantiated twice, once for candidate selection and once for highest-ISR/EOI selection.

## Test plan
- Init with ICW1=13h, ICW2=08h, ICW4=01h; OCW1=00h; pulse ir[3] high → int_o=1; two INTA pulses → vec_o=0Bh during the second pulse; ISR=08h; int_o=0.
- ir[5] then ir[2] active with ISR[3] set → only IR2 raises int_o; after OCW2=20h, ISR[3] clears, then IR2 is acknowledged before IR5.
- OCW1=04h with ir[2] pulsed → no int_o; OCW1=00h → int_o rises 1 cycle later.
- ICW4=03h (AEOI) → after the second INTA rising edge ISR=00h; OCW3=0Bh with a0=0 → rd_reg=ISR.
- PIC_ROTATION_EN: OCW2=C4h (lp=4), ir[3] and ir[5] both pending → vector id 5 is acknowledged first.
- INTA with no pending request → vector {base,7}, ISR=00h; assert rst during ACK2 → vec_oe=0 and all registers at reset values.
